mem_port_arbiter: RTL and testbench

Shares the single unified memory port between the pipeline's instruction-fetch requester (read-only) and data-memory requester (load/store). Data requests win by default, with a bounded-starvation rule so fetch always progresses. The block holds one outstanding access at a time and enforces a timeout on the memory response. It also drives the pipeline stall signal.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_timer.sv | 38 +++
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings and default tuning constants for the unified memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  localparam int unsigned WIN_LIMIT_DEF = 4;
  localparam int unsigned TIMEOUT_DEF   = 16;

endpackage

// File: rtl/mem_arb_timer.sv
// Clearable up-counter; expired is high while count equals TIMEOUT.
// Latency: expired is registered, visible the cycle after the count lands on TIMEOUT.
// Backpressure: none; en and clr are sampled every cycle, clr has priority.
module mem_arb_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data requesters, one access in flight.
// Latency: grant in IDLE, mem_req next cycle, done same cycle as mem_ready (or at timeout).
// Backpressure: requesters hold req until done; stall covers every pending-not-done requester.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned WIN_LIMIT = WIN_LIMIT_DEF,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_adr,
  output logic          if_done,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_adr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_done,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall,
  output logic          err
);

  localparam logic [3:0] WIN_LIM = 4'(WIN_LIMIT);

  state_e        state_q,     state_d;
  owner_e        owner_q,     owner_d;
  logic [3:0]    streak_q,    streak_d;
  logic          mem_we_q,    mem_we_d;
  logic [AW-1:0] mem_adr_q,   mem_adr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          err_q,       err_d;

  logic busy, grant, timer_en, timer_expired;
  logic fin_ok, fin_to, fin, rd_pass;

  assign busy    = (state_q == ST_BUSY);
  // mem_ready beats a coinciding expiry, so the timeout path is gated by ~mem_ready.
  assign fin_ok  = busy & mem_ready;
  assign fin_to  = busy & ~mem_ready & timer_expired;
  assign fin     = fin_ok | fin_to;
  assign rd_pass = fin_ok & ~mem_we_q;

  assign timer_en = busy & ~mem_ready & ~timer_expired;

  mem_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (grant),
    .en      (timer_en),
    .expired (timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    streak_d    = streak_q;
    mem_we_d    = mem_we_q;
    mem_adr_d   = mem_adr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;
    grant       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dm_req && (!if_req || streak_q != WIN_LIM)) begin
          grant       = 1'b1;
          state_d     = ST_BUSY;
          owner_d     = OWN_DM;
          mem_we_d    = dm_we;
          mem_adr_d   = dm_adr;
          mem_wdata_d = dm_wdata;
          if (!if_req) begin
            streak_d = '0;
          end else if (streak_q != WIN_LIM) begin
            streak_d = streak_q + 4'd1;
          end
        end else if (if_req) begin
          grant       = 1'b1;
          state_d     = ST_BUSY;
          owner_d     = OWN_IF;
          mem_we_d    = 1'b0;
          mem_adr_d   = if_adr;
          mem_wdata_d = '0;
          streak_d    = '0;
        end
      end
      ST_BUSY: begin
        if (fin) begin
          state_d = ST_IDLE;
        end
        if (fin_to) begin
          err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      streak_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_adr_q   <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      streak_q    <= streak_d;
      mem_we_q    <= mem_we_d;
      mem_adr_q   <= mem_adr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
    end
  end

  assign if_done   = fin & (owner_q == OWN_IF);
  assign dm_done   = fin & (owner_q == OWN_DM);
  assign if_rdata  = (if_done & rd_pass) ? mem_rdata : '0;
  assign dm_rdata  = (dm_done & rd_pass) ? mem_rdata : '0;

  assign mem_req   = busy;
  assign mem_we    = mem_we_q;
  assign mem_adr   = mem_adr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;

  assign stall = (if_req & ~if_done) | (dm_req & ~dm_done);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, store, arbitration fairness, timeout, async reset.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_adr;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_adr;
  logic [31:0] dm_wdata;
  logic        dm_done;
  logic [31:0] dm_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_adr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        err;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(
    .AW        (32),
    .DW        (32),
    .WIN_LIMIT (4),
    .TIMEOUT   (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_adr    (if_adr),
    .if_done   (if_done),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_adr    (dm_adr),
    .dm_wdata  (dm_wdata),
    .dm_done   (dm_done),
    .dm_rdata  (dm_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_adr   (mem_adr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .stall     (stall),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Both requesters held, mem_ready high: pat bit i = 1 means access i goes to DM.
  task automatic arb_seq(input int n, input logic [7:0] pat);
    for (int i = 0; i < n; i++) begin
      cyc();
      @(negedge clk);
      chk1("arb_mem_req", mem_req, 1'b1);
      chk1("arb_dm_done", dm_done, pat[i]);
      chk1("arb_if_done", if_done, !pat[i]);
      chk32("arb_adr", mem_adr, pat[i] ? 32'h300 : 32'h200);
      chk32("arb_dm_rdata", dm_rdata, pat[i] ? 32'hCAFE : 32'h0);
      chk32("arb_if_rdata", if_rdata, pat[i] ? 32'h0 : 32'hCAFE);
      chk1("arb_stall", stall, 1'b1);
      cyc();
      @(negedge clk);
      chk1("arb_turnaround", mem_req, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b0;
    if_req = 1'b0; if_adr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_adr = '0; dm_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk32("rst_mem_adr", mem_adr, 32'h0);
    chk32("rst_mem_wdata", mem_wdata, 32'h0);
    chk1("rst_if_done", if_done, 1'b0);
    chk1("rst_dm_done", dm_done, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_stall", stall, 1'b0);
    chk32("rst_if_rdata", if_rdata, 32'h0);
    chk32("rst_dm_rdata", dm_rdata, 32'h0);
    cyc();
    rst = 1'b1;

    // single fetch, ready one cycle after mem_req
    if_req = 1'b1; if_adr = 32'h40;
    @(negedge clk);
    chk1("f_idle_mem_req", mem_req, 1'b0);
    chk1("f_idle_stall", stall, 1'b1);
    cyc();
    @(negedge clk);
    chk1("f_mem_req", mem_req, 1'b1);
    chk32("f_mem_adr", mem_adr, 32'h40);
    chk1("f_mem_we", mem_we, 1'b0);
    chk32("f_mem_wdata", mem_wdata, 32'h0);
    chk1("f_no_early_done", if_done, 1'b0);
    cyc();
    mem_ready = 1'b1; mem_rdata = 32'h1234;
    @(negedge clk);
    chk1("f_done", if_done, 1'b1);
    chk32("f_rdata", if_rdata, 32'h1234);
    chk1("f_stall_released", stall, 1'b0);
    chk1("f_dm_done", dm_done, 1'b0);
    cyc();
    if_req = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    @(negedge clk);
    chk1("f_back_idle", mem_req, 1'b0);
    chk1("f_done_one_cycle", if_done, 1'b0);

    // store held until mem_ready
    dm_req = 1'b1; dm_we = 1'b1; dm_adr = 32'h100; dm_wdata = 32'hDEADBEEF;
    cyc();
    @(negedge clk);
    chk1("s_mem_req", mem_req, 1'b1);
    chk1("s_mem_we", mem_we, 1'b1);
    chk32("s_mem_adr", mem_adr, 32'h100);
    chk32("s_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk1("s_no_done", dm_done, 1'b0);
    cyc();
    @(negedge clk);
    chk32("s_wdata_held", mem_wdata, 32'hDEADBEEF);
    chk32("s_adr_held", mem_adr, 32'h100);
    cyc();
    mem_ready = 1'b1; mem_rdata = 32'h5555;
    @(negedge clk);
    chk1("s_done", dm_done, 1'b1);
    chk32("s_rdata_zero", dm_rdata, 32'h0);
    chk1("s_if_done", if_done, 1'b0);
    cyc();
    dm_req = 1'b0; dm_we = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    chk1("s_back_idle", mem_req, 1'b0);

    // both held: DM x4 then IF then DM
    if_req = 1'b1; if_adr = 32'h200;
    dm_req = 1'b1; dm_we = 1'b0; dm_adr = 32'h300; dm_wdata = 32'h0;
    mem_ready = 1'b1; mem_rdata = 32'hCAFE;
    arb_seq(6, 8'b0010_1111);
    if_req = 1'b0; dm_req = 1'b0; mem_ready = 1'b0;
    cyc();
    @(negedge clk);
    chk1("arb_quiet", mem_req, 1'b0);

    // mem_ready coinciding with expiry completes normally
    dm_req = 1'b1; dm_adr = 32'h600; mem_rdata = 32'h7777;
    repeat (16) begin
      cyc();
      @(negedge clk);
      chk1("c_wait_no_done", dm_done, 1'b0);
    end
    cyc();
    mem_ready = 1'b1;
    @(negedge clk);
    chk1("c_done", dm_done, 1'b1);
    chk32("c_rdata", dm_rdata, 32'h7777);
    cyc();
    dm_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    chk1("c_err_clear", err, 1'b0);
    chk1("c_idle", mem_req, 1'b0);

    // timeout with no mem_ready
    dm_req = 1'b1; dm_adr = 32'h400; mem_rdata = 32'h9999;
    repeat (16) begin
      cyc();
      @(negedge clk);
      chk1("t_wait_no_done", dm_done, 1'b0);
      chk1("t_wait_mem_req", mem_req, 1'b1);
    end
    cyc();
    @(negedge clk);
    chk1("t_done", dm_done, 1'b1);
    chk32("t_rdata_zero", dm_rdata, 32'h0);
    chk1("t_err_not_yet", err, 1'b0);
    cyc();
    dm_req = 1'b0;
    @(negedge clk);
    chk1("t_err_set", err, 1'b1);
    chk1("t_idle", mem_req, 1'b0);
    if_req = 1'b1; if_adr = 32'h44;
    cyc();
    mem_ready = 1'b1; mem_rdata = 32'hABCD;
    @(negedge clk);
    chk1("t_after_done", if_done, 1'b1);
    chk32("t_after_rdata", if_rdata, 32'hABCD);
    cyc();
    if_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    chk1("t_err_sticky", err, 1'b1);

    // async reset mid-access, then streak restarts from 0
    if_req = 1'b1; if_adr = 32'h200;
    dm_req = 1'b1; dm_we = 1'b0; dm_adr = 32'h300; mem_rdata = 32'hCAFE;
    cyc();
    #2;
    chk1("r_busy_before", mem_req, 1'b1);
    rst = 1'b0;
    #1;
    chk1("r_mem_req_async", mem_req, 1'b0);
    chk1("r_dm_done", dm_done, 1'b0);
    chk32("r_mem_adr", mem_adr, 32'h0);
    chk1("r_err_cleared", err, 1'b0);
    @(negedge clk);
    chk1("r_held_mem_req", mem_req, 1'b0);
    cyc();
    rst = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    chk1("r_idle_after", mem_req, 1'b0);
    arb_seq(5, 8'b0000_1111);
    if_req = 1'b0; dm_req = 1'b0; mem_ready = 1'b0;
    cyc();
    @(negedge clk);
    chk1("end_idle", mem_req, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
